booth_seq_mul: RTL and testbench

//   Sequential, parametrised signed Booth multiplier; successor to the combinational 4x4 Booth block.

---
 rtl/booth_pkg.sv | 19 +
 rtl/booth_recode.sv | 35 +++
 rtl/booth_seq_mul.sv | 121 ++++++++++++
 tb/tb_booth_seq_mul.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/booth_pkg.sv
// rtl/booth_pkg.sv - shared types and iteration helper for the sequential Booth multiplier
// BOOTH_RADIX4_EN selects modified-Booth (two bits per step) instead of radix-2.
package booth_pkg;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  typedef enum logic [2:0] {OP_ZERO, OP_ADD1, OP_SUB1, OP_ADD2, OP_SUB2} op_t;

`ifdef BOOTH_RADIX4_EN
  localparam int STEP_BITS = 2;
`else
  localparam int STEP_BITS = 1;
`endif

  function automatic int iter_count(input int width);
    return width / STEP_BITS;
  endfunction

endpackage

// File: rtl/booth_recode.sv
// rtl/booth_recode.sv - Booth digit recoder, {Q[1],Q[0],q_1} -> add/sub operation
// BOOTH_RADIX4_EN selects the modified-Booth table; otherwise only {Q[0],q_1} matter.
module booth_recode
  import booth_pkg::*;
(
  input  logic [2:0] sel_i,
  output op_t        op_o
);

`ifdef BOOTH_RADIX4_EN
  always_comb begin
    op_o = OP_ZERO;
    case (sel_i)
      3'b001, 3'b010: op_o = OP_ADD1;
      3'b011:         op_o = OP_ADD2;
      3'b100:         op_o = OP_SUB2;
      3'b101, 3'b110: op_o = OP_SUB1;
      default:        op_o = OP_ZERO;
    endcase
  end
`else
  logic unused_q1;
  assign unused_q1 = sel_i[2];

  always_comb begin
    op_o = OP_ZERO;
    case (sel_i[1:0])
      2'b01:   op_o = OP_ADD1;
      2'b10:   op_o = OP_SUB1;
      default: op_o = OP_ZERO;
    endcase
  end
`endif

endmodule

// File: rtl/booth_seq_mul.sv
// rtl/booth_seq_mul.sv - sequential signed Booth multiplier, one recode step per clock
// BOOTH_RADIX4_EN selects modified-Booth (WIDTH/2 steps); default is radix-2 (WIDTH steps).
module booth_seq_mul
  import booth_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     m,
  input  logic [WIDTH-1:0]     r,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   p
);

  localparam int N  = iter_count(WIDTH);
  // One guard bit absorbs -M for m = -2^(WIDTH-1); radix-4 needs another for +-2M.
  localparam int AW = WIDTH + STEP_BITS;
  localparam int CW = $clog2(N + 1);

  if (WIDTH < 2 || (STEP_BITS == 2 && (WIDTH % 2) != 0)) begin : g_bad_width
    $error("booth_seq_mul: WIDTH must be >= 2 and even for radix-4");
  end

  state_t                state_q, state_d;
  logic [AW-1:0]         m_q, m_d;
  logic [AW-1:0]         a_q, a_d;
  logic [WIDTH-1:0]      q_q, q_d;
  logic                  q1_q, q1_d;
  logic [CW-1:0]         count_q, count_d;
  logic [2*WIDTH-1:0]    p_q, p_d;

  op_t                   op;
  logic [AW-1:0]         addend;
  logic [AW-1:0]         sum;
  logic signed [AW+WIDTH:0] shifted;

  booth_recode u_recode (
    .sel_i ({q_q[1:0], q1_q}),
    .op_o  (op)
  );

  always_comb begin
    addend = '0;
    case (op)
      OP_ADD1: addend = m_q;
      OP_SUB1: addend = -m_q;
      OP_ADD2: addend = m_q << 1;
      OP_SUB2: addend = -(m_q << 1);
      default: addend = '0;
    endcase
  end

  assign sum     = a_q + addend;
  assign shifted = $signed({sum, q_q, q1_q}) >>> STEP_BITS;

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    a_d     = a_q;
    q_d     = q_q;
    q1_d    = q1_q;
    count_d = count_q;
    p_d     = p_q;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          m_d     = {{(AW-WIDTH){m[WIDTH-1]}}, m};
          a_d     = '0;
          q_d     = r;
          q1_d    = 1'b0;
          count_d = CW'(N);
        end
      end
      S_RUN: begin
        busy    = 1'b1;
        a_d     = shifted[AW+WIDTH -: AW];
        q_d     = shifted[WIDTH:1];
        q1_d    = shifted[0];
        count_d = count_q - CW'(1);
        if (count_q == CW'(1)) begin
          state_d = S_DONE;
          p_d     = {shifted[WIDTH+1 +: WIDTH], shifted[WIDTH:1]};
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      m_q     <= '0;
      a_q     <= '0;
      q_q     <= '0;
      q1_q    <= 1'b0;
      count_q <= '0;
      p_q     <= '0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      a_q     <= a_d;
      q_q     <= q_d;
      q1_q    <= q1_d;
      count_q <= count_d;
      p_q     <= p_d;
    end
  end

  assign p = p_q;

endmodule

// File: tb/tb_booth_seq_mul.sv
// tb/tb_booth_seq_mul.sv - directed self-checking bench for booth_seq_mul (WIDTH=4)
module tb_booth_seq_mul;

  localparam int WIDTH = 4;
`ifdef BOOTH_RADIX4_EN
  localparam int N = 2;
`else
  localparam int N = 4;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [3:0] m;
  logic [3:0] r;
  logic       busy;
  logic       done;
  logic [7:0] p;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  booth_seq_mul #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .m     (m),
    .r     (r),
    .busy  (busy),
    .done  (done),
    .p     (p)
  );

  // Latency counts the accept edge as edge 1, so done is expected after edge N+1.
  task automatic do_mul(input logic [3:0] mm, input logic [3:0] rr,
                        output logic [7:0] prod, output int lat, output logic busy_seen);
    int w;
    @(negedge clk);
    w = 0;
    while ((busy || done) && w < 20) begin
      @(negedge clk);
      w++;
    end
    checks++;
    if (w >= 20) begin
      errors++;
      $display("FAIL idle_wait: busy=%b done=%b required 0/0", busy, done);
    end
    m = mm;
    r = rr;
    start = 1'b1;
    @(posedge clk);
    #1;
    busy_seen = busy;
    lat = 1;
    @(negedge clk);
    start = 1'b0;
    m = ~mm;
    r = ~rr;
    while (!done && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    prod = p;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    m = 4'h0;
    r = 4'h0;
    #12;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++;
    if (p !== 8'h00) begin errors++; $display("FAIL reset_p: got %h expected 00", p); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    logic [7:0] prod;
    int lat;
    logic bs;
    do_mul(4'd4, 4'd2, prod, lat, bs);
    checks++;
    if (bs !== 1'b1) begin errors++; $display("FAIL basic_busy: got %b expected 1", bs); end
    checks++;
    if (lat != N + 1) begin errors++; $display("FAIL basic_latency: got %0d expected %0d", lat, N + 1); end
    checks++;
    if (prod !== 8'h08) begin errors++; $display("FAIL basic_p: got %h expected 08", prod); end
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      checks++;
      if (done !== 1'b0) begin errors++; $display("FAIL basic_done_pulse: got %b expected 0 (cycle %0d)", done, k); end
      checks++;
      if (p !== 8'h08) begin errors++; $display("FAIL basic_p_hold: got %h expected 08 (cycle %0d)", p, k); end
    end
  endtask

  task automatic test_signed();
    logic [3:0] tm [4] = '{4'hD, 4'h5, 4'h8, 4'h8};
    logic [3:0] tr [4] = '{4'h5, 4'hD, 4'h8, 4'h7};
    logic [7:0] te [4] = '{8'hF1, 8'hF1, 8'h40, 8'hC8};
    logic [7:0] prod;
    int lat;
    logic bs;
    for (int k = 0; k < 4; k++) begin
      do_mul(tm[k], tr[k], prod, lat, bs);
      checks++;
      if (prod !== te[k]) begin
        errors++;
        $display("FAIL signed_p: m=%h r=%h got %h expected %h", tm[k], tr[k], prod, te[k]);
      end
      checks++;
      if (lat != N + 1) begin errors++; $display("FAIL signed_latency: got %0d expected %0d", lat, N + 1); end
    end
  endtask

  task automatic test_exhaustive();
    logic signed [3:0] sm;
    logic signed [3:0] sr;
    logic signed [7:0] e;
    logic [7:0] prod;
    int lat;
    logic bs;
    for (int i = 0; i < 256; i++) begin
      sm = 4'(i >> 4);
      sr = 4'(i);
      e = sm * sr;
      do_mul(sm, sr, prod, lat, bs);
      checks++;
      if (prod !== e) begin
        errors++;
        $display("FAIL exhaustive_p: m=%h r=%h got %h expected %h", sm, sr, prod, e);
      end
      checks++;
      if (lat != N + 1) begin
        errors++;
        $display("FAIL exhaustive_done: m=%h r=%h latency %0d expected %0d", sm, sr, lat, N + 1);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] bm [3] = '{4'h3, 4'h8, 4'h7};
    logic [3:0] br [3] = '{4'h9, 4'hF, 4'h6};
    logic [7:0] be [3] = '{8'hEB, 8'h08, 8'h2A};
    int phase;
    int idx;
    logic exp_done;
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    for (int c = 0; c < 3 * (N + 2); c++) begin
      phase = c % (N + 2);
      idx = c / (N + 2);
      @(negedge clk);
      start = 1'b1;
      if (phase == 0) begin
        m = bm[idx];
        r = br[idx];
      end else begin
        m = 4'h1 + 4'(phase);
        r = 4'h1;
      end
      @(posedge clk);
      #1;
      exp_done = (phase == N);
      checks++;
      if (done !== exp_done) begin
        errors++;
        $display("FAIL b2b_done: cycle %0d got %b expected %b", c, done, exp_done);
      end
      if (exp_done) begin
        checks++;
        if (p !== be[idx]) begin
          errors++;
          $display("FAIL b2b_p: product %0d got %h expected %h", idx, p, be[idx]);
        end
      end
    end
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL b2b_idle: busy got %b expected 0", busy); end
  endtask

  task automatic test_reset_mid();
    logic saw_done;
    logic [7:0] prod;
    int lat;
    logic bs;
    @(negedge clk);
    m = 4'h3;
    r = 4'h3;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL midreset_busy: got %b expected 0", busy); end
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL midreset_done: got %b expected 0", done); end
    checks++;
    if (p !== 8'h00) begin errors++; $display("FAIL midreset_p: got %h expected 00", p); end
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    saw_done = 1'b0;
    for (int k = 0; k < 2 * N + 4; k++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) saw_done = 1'b1;
    end
    checks++;
    if (saw_done !== 1'b0) begin errors++; $display("FAIL midreset_no_done: got %b expected 0", saw_done); end
    do_mul(4'h6, 4'hE, prod, lat, bs);
    checks++;
    if (prod !== 8'hF4) begin errors++; $display("FAIL midreset_restart_p: got %h expected f4", prod); end
    checks++;
    if (lat != N + 1) begin errors++; $display("FAIL midreset_restart_latency: got %0d expected %0d", lat, N + 1); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_signed();
    test_exhaustive();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
